ofs_axis_mmio_responder: RTL

Synthesizable AXI-S MMIO completer, the responder counterpart to the host-side AXI-S TLP BFM. It accepts single-beat memory read/write TLPs from the PCIe RX stream, services them against a local bank of 64-bit registers, and returns completions on the TX stream. It sits behind the PF/VF mux as a test/scratch endpoint and is exercised directly by the top-level bench.

---
 rtl/ofs_axis_mmio_pkg.sv | 98 +++++++++
 rtl/ofs_axis_mmio_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ofs_axis_mmio_pkg.sv
// Shared types, TLP field encodings and decode helpers for the AXI-S MMIO responder.
package ofs_axis_mmio_pkg;

    // TLP fmt encodings (3DW/4DW, with/without data)
    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

    // TLP type encodings
    localparam logic [4:0] TYPE_MEM = 5'b00000;
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    // Completion status codes
    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RESP       = 2'd1,
        ST_DRAIN      = 2'd2,
        ST_DRAIN_RESP = 2'd3
    } state_e;

    // Request header as laid out in tdata[127:0], DW0 in the low bits
    typedef struct packed {
        logic [31:0] dw3;
        logic [31:0] dw2;
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [3:0]  last_be;
        logic [3:0]  first_be;
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic [13:0] rsvd0;
        logic [9:0]  length;
    } req_hdr_t;

    // Completion header as laid out in tdata[95:0], DW0 in the low bits
    typedef struct packed {
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic        rsvd2;
        logic [6:0]  lower_addr;
        logic [15:0] cpl_id;
        logic [2:0]  status;
        logic        bcm;
        logic [11:0] byte_count;
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic [13:0] rsvd0;
        logic [9:0]  length;
    } cpl_hdr_t;

    // Decoded view of one request beat
    typedef struct packed {
        logic       supported;
        logic       is_read;
        logic [7:0] idx;
        logic       half;
        logic [1:0] len;
        logic [6:0] lower_addr;
    } dec_t;

    // Byte-enable merge of a new dword over an old one
    function automatic logic [31:0] be_merge(input logic [31:0] old_dw,
                                             input logic [31:0] new_dw,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_dw[b*8 +: 8] : old_dw[b*8 +: 8];
        end
        return res;
    endfunction

    // Classify a request header; idx_lg is log2 of the register count
    function automatic dec_t decode_req(input req_hdr_t h,
                                        input logic     last,
                                        input int unsigned idx_lg);
        dec_t        d;
        logic [63:0] addr;
        logic        mem;
        logic        len_ok;
        addr   = h.fmt[0] ? {h.dw2, h.dw3} : {32'd0, h.dw2};
        mem    = (h.typ == TYPE_MEM) && (h.fmt[2] == 1'b0);
        // A two-dword access must not straddle two registers
        len_ok = (h.length == 10'd1) || ((h.length == 10'd2) && (addr[2] == 1'b0));
        d.is_read    = mem && (h.fmt[1] == 1'b0);
        d.idx        = addr[10:3];
        d.half       = addr[2];
        d.len        = h.length[1:0];
        d.lower_addr = {addr[6:2], 2'b00};
        d.supported  = mem && last && len_ok && (addr[1:0] == 2'b00) &&
                       ((addr >> (idx_lg + 32'd3)) == 64'd0);
        return d;
    endfunction

endpackage

// File: rtl/ofs_axis_mmio_responder.sv
// Single-beat MMIO completer: services MRd/MWr TLPs against a local 64-bit register bank.
module ofs_axis_mmio_responder
    import ofs_axis_mmio_pkg::*;
#(
    parameter int          DATA_W   = 512,
    parameter int          NUM_REGS = 16,
    parameter logic [15:0] CPL_ID   = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_tvalid,
    output logic                  rx_tready,
    input  logic [DATA_W-1:0]     rx_tdata,
    input  logic                  rx_tlast,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    output logic [DATA_W-1:0]     tx_tdata,
    output logic [DATA_W/8-1:0]   tx_tkeep,
    output logic                  tx_tlast,
    output logic [15:0]           ur_count
);

    localparam int unsigned IDX_LG = $clog2(NUM_REGS);
    localparam int          IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int          KEEP_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                rx_tready_q, rx_tready_d;
    logic                tx_tvalid_q, tx_tvalid_d;
    logic [DATA_W-1:0]   tx_tdata_q, tx_tdata_d;
    logic [KEEP_W-1:0]   tx_tkeep_q, tx_tkeep_d;
    logic [15:0]         ur_count_q, ur_count_d;
    logic [63:0]         regs_q [NUM_REGS];
    logic [63:0]         regs_d [NUM_REGS];

    req_hdr_t            hdr_s;
    dec_t                dec_s;
    logic [IDX_W-1:0]    idx_s;
    logic [63:0]         wdata_s;
    logic [63:0]         rd_reg_s;
    logic                accept_s;
    logic                new_req_s;
    logic                wr_en_s;
    logic                cap_s;
    logic                ur_inc_s;
    cpl_hdr_t            cpl_hdr_s;
    int                  keep_bytes_s;

    // Decode the beat on the request stream and derive the per-cycle actions
    always_comb begin
        hdr_s     = req_hdr_t'(rx_tdata[127:0]);
        dec_s     = decode_req(hdr_s, rx_tlast, IDX_LG);
        idx_s     = dec_s.idx[IDX_W-1:0];
        wdata_s   = rx_tdata[191:128];
        rd_reg_s  = regs_q[idx_s];
        accept_s  = rx_tvalid && rx_tready_q;
        new_req_s = accept_s && (state_q == ST_IDLE);
        wr_en_s   = new_req_s && dec_s.supported && !dec_s.is_read;
        cap_s     = new_req_s && dec_s.is_read;
        ur_inc_s  = new_req_s && !dec_s.supported;
    end

    // Next-state logic; ready/valid are registered from the next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (new_req_s && !rx_tlast) begin
                    state_d = dec_s.is_read ? ST_DRAIN_RESP : ST_DRAIN;
                end else if (new_req_s && dec_s.is_read) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (tx_tready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (accept_s && rx_tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN_RESP: begin
                if (accept_s && rx_tlast) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_DRAIN_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rx_tready_d = (state_d != ST_RESP);
        tx_tvalid_d = (state_d == ST_RESP);
    end

    // Register-bank write path with per-byte enables
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en_s) begin
            if (dec_s.len == 2'd2) begin
                regs_d[idx_s] = {be_merge(rd_reg_s[63:32], wdata_s[63:32], hdr_s.last_be),
                                 be_merge(rd_reg_s[31:0],  wdata_s[31:0],  hdr_s.first_be)};
            end else if (dec_s.half) begin
                regs_d[idx_s][63:32] = be_merge(rd_reg_s[63:32], wdata_s[31:0], hdr_s.first_be);
            end else begin
                regs_d[idx_s][31:0]  = be_merge(rd_reg_s[31:0],  wdata_s[31:0], hdr_s.first_be);
            end
        end else begin
            regs_d[idx_s] = regs_q[idx_s];
        end
    end

    // Build the completion beat; it is captured only when a read is accepted
    always_comb begin
        cpl_hdr_s            = '0;
        cpl_hdr_s.req_id     = hdr_s.req_id;
        cpl_hdr_s.tag        = hdr_s.tag;
        cpl_hdr_s.lower_addr = dec_s.lower_addr;
        cpl_hdr_s.cpl_id     = CPL_ID;
        cpl_hdr_s.typ        = TYPE_CPL;
        tx_tdata_d           = tx_tdata_q;
        tx_tkeep_d           = tx_tkeep_q;
        if (dec_s.supported) begin
            cpl_hdr_s.fmt        = FMT_3DW_DATA;
            cpl_hdr_s.status     = CPL_SC;
            cpl_hdr_s.length     = {8'd0, dec_s.len};
            cpl_hdr_s.byte_count = {8'd0, dec_s.len, 2'b00};
            keep_bytes_s         = 16 + 4 * int'(dec_s.len);
        end else begin
            cpl_hdr_s.fmt        = FMT_3DW_NODATA;
            cpl_hdr_s.status     = CPL_UR;
            cpl_hdr_s.length     = 10'd0;
            cpl_hdr_s.byte_count = 12'd0;
            keep_bytes_s         = 12;
        end
        if (cap_s) begin
            tx_tdata_d        = '0;
            tx_tdata_d[95:0]  = cpl_hdr_s;
            if (dec_s.supported && (dec_s.len == 2'd2)) begin
                tx_tdata_d[191:128] = rd_reg_s;
            end else if (dec_s.supported) begin
                tx_tdata_d[159:128] = dec_s.half ? rd_reg_s[63:32] : rd_reg_s[31:0];
            end else begin
                tx_tdata_d[191:128] = 64'd0;
            end
            for (int k = 0; k < KEEP_W; k++) begin
                tx_tkeep_d[k] = (k < keep_bytes_s);
            end
        end else begin
            tx_tdata_d = tx_tdata_q;
        end
    end

    // Saturating count of unsupported requests
    always_comb begin
        if (ur_inc_s && (ur_count_q != 16'hFFFF)) begin
            ur_count_d = ur_count_q + 16'd1;
        end else begin
            ur_count_d = ur_count_q;
        end
    end

    // State, output and register-bank flops with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rx_tready_q <= 1'b0;
            tx_tvalid_q <= 1'b0;
            tx_tdata_q  <= '0;
            tx_tkeep_q  <= '0;
            ur_count_q  <= 16'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 64'd0;
            end
        end else begin
            state_q     <= state_d;
            rx_tready_q <= rx_tready_d;
            tx_tvalid_q <= tx_tvalid_d;
            tx_tdata_q  <= tx_tdata_d;
            tx_tkeep_q  <= tx_tkeep_d;
            ur_count_q  <= ur_count_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rx_tready = rx_tready_q;
    assign tx_tvalid = tx_tvalid_q;
    assign tx_tdata  = tx_tdata_q;
    assign tx_tkeep  = tx_tkeep_q;
    assign tx_tlast  = tx_tvalid_q;
    assign ur_count  = ur_count_q;

endmodule
